// File: rtl/kf8237_bus_cycle_sequencer.sv
// kf8237_bus_cycle_sequencer
//
// DMA bus-cycle state machine for the KF8237. It accepts a granted channel,
// runs the HRQ/HLDA handshake, steps through S0..S4 (plus SW wait states, or
// SC for cascade), and drives AEN/ADSTB, the address bytes and the
// memory/IO strobes. It also returns the next_word pulse that advances the
// upstream address/count register stage.
//
// State updates on the falling edge of clock. The reset is asynchronous and
// active-high.
//
// Optional feature macro: KF8237_EXTENDED_WRITE_EN. When it is defined, the
// write strobe (io_write / memory_write) starts in S2, together with the read
// strobe, rather than in S3.
//
// Ports:
//   clock, reset              system clock (negedge active), async reset
//   start_transfer            grant pulse; accepted only in SI
//   transfer_type[1:0]        00 verify, 01 write (IO->mem), 10 read (mem->IO), 11 verify
//   transfer_mode[1:0]        00 demand, 01 single, 10 block, 11 cascade
//   dreq_active               DREQ of the granted channel
//   hold_acknowledge          HLDA
//   ready                     wait-state request, sampled in S3 and SW
//   external_end_of_process   EOP input, sampled in S1..SW
//   transfer_address[15:0]    current address from the register stage
//   update_high_address       high byte changes on this advance (valid with next_word)
//   underflow                 word-count borrow (valid with next_word)
//   hold_request              HRQ
//   dma_acknowledge           DACK
//   address_enable            AEN
//   address_strobe            ADSTB
//   output_address_low[7:0]   low address byte while AEN, else 0
//   output_high_address[7:0]  high address byte as latched in S1
//   output_high_address_enable  drive the high byte onto the data bus (S1)
//   memory_read, memory_write, io_read, io_write   active-high strobes
//   next_word                 one-cycle advance pulse (S4)
//   end_of_process            one-cycle pulse after a TC- or EOP-terminated service
//   transfer_done             one-cycle pulse after any service ends
//   bus_state[2:0]            current state, for observation
//
// Handshake: start_transfer is a single-cycle request. It is taken only when
// bus_state is SI; while the sequencer is busy, it is ignored and not queued.
// next_word is a one-cycle strobe with no back-pressure. update_high_address
// and underflow are trusted only during that cycle.
module kf8237_bus_cycle_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_transfer,
    input  logic [1:0]  transfer_type,
    input  logic [1:0]  transfer_mode,
    input  logic        dreq_active,
    input  logic        hold_acknowledge,
    input  logic        ready,
    input  logic        external_end_of_process,
    input  logic [15:0] transfer_address,
    input  logic        update_high_address,
    input  logic        underflow,
    output logic        hold_request,
    output logic        dma_acknowledge,
    output logic        address_enable,
    output logic        address_strobe,
    output logic [7:0]  output_address_low,
    output logic [7:0]  output_high_address,
    output logic        output_high_address_enable,
    output logic        memory_read,
    output logic        memory_write,
    output logic        io_read,
    output logic        io_write,
    output logic        next_word,
    output logic        end_of_process,
    output logic        transfer_done,
    output logic [2:0]  bus_state
);

    typedef enum logic [2:0] {
        SI = 3'd0,
        S0 = 3'd1,
        S1 = 3'd2,
        S2 = 3'd3,
        S3 = 3'd4,
        SW = 3'd5,
        S4 = 3'd6,
        SC = 3'd7
    } state_t;

    localparam logic [1:0] MODE_DEMAND  = 2'b00;
    localparam logic [1:0] MODE_SINGLE  = 2'b01;
    localparam logic [1:0] MODE_CASCADE = 2'b11;
    localparam logic [1:0] TYPE_WRITE   = 2'b01;
    localparam logic [1:0] TYPE_READ    = 2'b10;

    state_t     state, state_next;
    logic       need_s1, need_s1_next;
    logic       eop_latch, eop_latch_next;
    logic       eop_pulse_next, done_pulse_next;
    logic [7:0] high_latch;
    logic [1:0] cur_type, cur_mode;
    logic       in_cycle;
    logic       read_window, late_window, write_window;
    logic       is_read, is_write;

    // Type and mode are captured at the grant. This keeps every output a
    // decode of registered state for the whole service.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state          <= SI;
            need_s1        <= 1'b0;
            eop_latch      <= 1'b0;
            high_latch     <= 8'h00;
            cur_type       <= 2'b00;
            cur_mode       <= 2'b00;
            end_of_process <= 1'b0;
            transfer_done  <= 1'b0;
        end else begin
            state          <= state_next;
            need_s1        <= need_s1_next;
            eop_latch      <= eop_latch_next;
            end_of_process <= eop_pulse_next;
            transfer_done  <= done_pulse_next;
            if (state == SI && start_transfer) begin
                cur_type <= transfer_type;
                cur_mode <= transfer_mode;
            end
            if (state == S1) begin
                high_latch <= transfer_address[15:8];
            end
        end
    end

    assign in_cycle = (state == S1) || (state == S2) || (state == S3) || (state == SW);

    always_comb begin
        state_next      = state;
        need_s1_next    = need_s1;
        eop_latch_next  = eop_latch;
        eop_pulse_next  = 1'b0;
        done_pulse_next = 1'b0;
        case (state)
            SI: begin
                eop_latch_next = 1'b0;
                if (start_transfer) state_next = S0;
            end
            S0: begin
                // The first transfer of a service always issues the high byte.
                need_s1_next = 1'b1;
                if (hold_acknowledge) state_next = (cur_mode == MODE_CASCADE) ? SC : S1;
            end
            S1: state_next = S2;
            S2: state_next = S3;
            S3: state_next = ready ? S4 : SW;
            SW: state_next = ready ? S4 : SW;
            S4: begin
                need_s1_next = update_high_address;
                if (underflow || eop_latch || (cur_mode == MODE_SINGLE) ||
                    ((cur_mode == MODE_DEMAND) && !dreq_active)) begin
                    state_next      = SI;
                    done_pulse_next = 1'b1;
                    eop_pulse_next  = underflow || eop_latch;
                end else begin
                    state_next = need_s1_next ? S1 : S2;
                end
            end
            SC: begin
                if (!dreq_active) begin
                    state_next      = SI;
                    done_pulse_next = 1'b1;
                end
            end
            default: state_next = SI;
        endcase

        if (in_cycle && external_end_of_process) eop_latch_next = 1'b1;

        // Losing the bus mid-cycle abandons the transfer. There is no advance
        // and no EOP, but the service is still reported as finished.
        if (in_cycle && !hold_acknowledge) begin
            state_next      = SI;
            done_pulse_next = 1'b1;
            eop_pulse_next  = 1'b0;
        end
    end

    // Strobes stay asserted through S4, so the data phase completes at the
    // S4 edge. The read strobe opens in S2 and the write strobe opens in S3.
    assign read_window = (state == S2) || (state == S3) || (state == SW) || (state == S4);
    assign late_window = (state == S3) || (state == SW) || (state == S4);
`ifdef KF8237_EXTENDED_WRITE_EN
    assign write_window = read_window;
`else
    assign write_window = late_window;
`endif

    assign is_read  = (cur_type == TYPE_READ);
    assign is_write = (cur_type == TYPE_WRITE);

    always_comb begin
        hold_request               = (state != SI);
        address_enable             = in_cycle || (state == S4);
        dma_acknowledge            = address_enable || (state == SC);
        address_strobe             = (state == S1);
        output_high_address_enable = (state == S1);
        output_address_low         = address_enable ? transfer_address[7:0] : 8'h00;
        output_high_address        = (state == S1) ? transfer_address[15:8] : high_latch;
        memory_read                = is_read  && read_window;
        io_write                   = is_read  && write_window;
        io_read                    = is_write && read_window;
        memory_write               = is_write && write_window;
        next_word                  = (state == S4);
        bus_state                  = state;
    end

endmodule

// File: tb/tb_kf8237_bus_cycle_sequencer.sv
module tb_kf8237_bus_cycle_sequencer;

    localparam logic [2:0] ST_SI = 3'd0;
    localparam logic [2:0] ST_S0 = 3'd1;
    localparam logic [2:0] ST_S1 = 3'd2;
    localparam logic [2:0] ST_S2 = 3'd3;
    localparam logic [2:0] ST_S3 = 3'd4;
    localparam logic [2:0] ST_SW = 3'd5;
    localparam logic [2:0] ST_S4 = 3'd6;
    localparam logic [2:0] ST_SC = 3'd7;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_transfer = 1'b0;
    logic [1:0]  transfer_type = 2'b00;
    logic [1:0]  transfer_mode = 2'b00;
    logic        dreq_active = 1'b0;
    logic        hold_acknowledge = 1'b0;
    logic        ready = 1'b1;
    logic        external_end_of_process = 1'b0;
    logic [15:0] transfer_address;
    logic        update_high_address, underflow;
    logic        hold_request, dma_acknowledge, address_enable, address_strobe;
    logic [7:0]  output_address_low, output_high_address;
    logic        output_high_address_enable;
    logic        memory_read, memory_write, io_read, io_write;
    logic        next_word, end_of_process, transfer_done;
    logic [2:0]  bus_state;

    int checks = 0;
    int errors = 0;

    kf8237_bus_cycle_sequencer dut (
        .clock(clock), .reset(reset), .start_transfer(start_transfer),
        .transfer_type(transfer_type), .transfer_mode(transfer_mode),
        .dreq_active(dreq_active), .hold_acknowledge(hold_acknowledge),
        .ready(ready), .external_end_of_process(external_end_of_process),
        .transfer_address(transfer_address),
        .update_high_address(update_high_address), .underflow(underflow),
        .hold_request(hold_request), .dma_acknowledge(dma_acknowledge),
        .address_enable(address_enable), .address_strobe(address_strobe),
        .output_address_low(output_address_low),
        .output_high_address(output_high_address),
        .output_high_address_enable(output_high_address_enable),
        .memory_read(memory_read), .memory_write(memory_write),
        .io_read(io_read), .io_write(io_write), .next_word(next_word),
        .end_of_process(end_of_process), .transfer_done(transfer_done),
        .bus_state(bus_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- upstream address/count stage model ----------------
    logic [15:0] m_addr = 16'h0000;
    logic [15:0] m_count = 16'h0000;
    logic [15:0] ld_addr = 16'h0000;
    logic [15:0] ld_count = 16'h0000;
    logic        ld_en = 1'b0;

    always @(negedge clock) begin
        if (ld_en) begin
            m_addr  <= ld_addr;
            m_count <= ld_count;
        end else if (next_word) begin
            m_addr  <= m_addr + 16'd1;
            m_count <= m_count - 16'd1;
        end
    end

    assign transfer_address    = m_addr;
    assign update_high_address = next_word && (m_addr[7:0] == 8'hFF);
    assign underflow           = next_word && (m_count == 16'h0000);

    wire [27:0] all_outs = {hold_request, dma_acknowledge, address_enable, address_strobe,
                            output_address_low, output_high_address, output_high_address_enable,
                            memory_read, memory_write, io_read, io_write,
                            next_word, end_of_process, transfer_done};

    // ---------------- per-cycle trace ----------------
    logic [2:0]  tr_st [0:63];
    logic [7:0]  tr_hi [0:63];
    logic [7:0]  tr_lo [0:63];
    logic [63:0] tr_mr, tr_mw, tr_ir, tr_iw, tr_nw, tr_eop, tr_td, tr_ads, tr_hrq, tr_dk, tr_ae;
    int          n_cap;

    task automatic clear_trace();
        n_cap = 0;
        {tr_mr, tr_mw, tr_ir, tr_iw, tr_nw, tr_eop} = '0;
        {tr_td, tr_ads, tr_hrq, tr_dk, tr_ae} = '0;
        for (int i = 0; i < 64; i++) begin
            tr_st[i] = 3'd0;
            tr_hi[i] = 8'h00;
            tr_lo[i] = 8'h00;
        end
    endtask

    // Samples on the rising edge, half a period away from the DUT's falling edge.
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            tr_st[n_cap]  = bus_state;
            tr_hi[n_cap]  = output_high_address;
            tr_lo[n_cap]  = output_address_low;
            tr_mr[n_cap]  = memory_read;
            tr_mw[n_cap]  = memory_write;
            tr_ir[n_cap]  = io_read;
            tr_iw[n_cap]  = io_write;
            tr_nw[n_cap]  = next_word;
            tr_eop[n_cap] = end_of_process;
            tr_td[n_cap]  = transfer_done;
            tr_ads[n_cap] = address_strobe;
            tr_hrq[n_cap] = hold_request;
            tr_dk[n_cap]  = dma_acknowledge;
            tr_ae[n_cap]  = address_enable;
            n_cap++;
            start_transfer = 1'b0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_stage(input logic [15:0] addr, input logic [15:0] count);
        ld_addr  = addr;
        ld_count = count;
        ld_en    = 1'b1;
        @(posedge clock);
        ld_en    = 1'b0;
    endtask

    task automatic begin_service(input logic [1:0] ttype, input logic [1:0] tmode);
        clear_trace();
        transfer_type    = ttype;
        transfer_mode    = tmode;
        dreq_active      = 1'b1;
        hold_acknowledge = 1'b1;
        ready            = 1'b1;
        start_transfer   = 1'b1;
    endtask

    task automatic go_idle();
        hold_acknowledge        = 1'b0;
        dreq_active             = 1'b0;
        ready                   = 1'b1;
        external_end_of_process = 1'b0;
        start_transfer          = 1'b0;
        repeat (2) @(posedge clock);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        load_stage(16'h0000, 16'h0000);
        repeat (2) @(posedge clock);
        checks++;
        if (all_outs !== 28'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", all_outs);
        end
        checks++;
        if (bus_state !== ST_SI) begin
            errors++;
            $display("FAIL reset_state: got %0d required %0d", bus_state, ST_SI);
        end
        reset = 1'b0;
        @(posedge clock);
    endtask

    task automatic test_single_read();
        logic [2:0] exp_q[$];
        exp_q = '{ST_S0, ST_S1, ST_S2, ST_S3, ST_S4, ST_SI};
        load_stage(16'h12FF, 16'h0005);
        begin_service(2'b10, 2'b01);
        capture(6);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (tr_st[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL single_state[%0d]: got %0d required %0d", i, tr_st[i], exp_q[i]);
            end
        end
        checks++;
        if (tr_ads !== 64'h2) begin errors++; $display("FAIL single_adstb: got %h required 2", tr_ads); end
        checks++;
        if (tr_hi[1] !== 8'h12) begin errors++; $display("FAIL single_high: got %h required 12", tr_hi[1]); end
        checks++;
        if (tr_lo[1] !== 8'hFF) begin errors++; $display("FAIL single_low: got %h required ff", tr_lo[1]); end
        checks++;
        if ($countones(tr_mr) !== 3) begin errors++; $display("FAIL single_memr: got %0d required 3", $countones(tr_mr)); end
        checks++;
        if ($countones(tr_iw) !== 2) begin errors++; $display("FAIL single_iow: got %0d required 2", $countones(tr_iw)); end
        checks++;
        if ((tr_ir | tr_mw) !== 64'h0) begin errors++; $display("FAIL single_other_strobes: got %h required 0", tr_ir | tr_mw); end
        checks++;
        if (tr_nw !== 64'h10) begin errors++; $display("FAIL single_next_word: got %h required 10", tr_nw); end
        checks++;
        if (tr_hrq !== 64'h1F) begin errors++; $display("FAIL single_hrq: got %h required 1f", tr_hrq); end
        checks++;
        if (tr_td !== 64'h20 || tr_eop !== 64'h0) begin
            errors++;
            $display("FAIL single_done: got td=%h eop=%h required td=20 eop=0", tr_td, tr_eop);
        end
        go_idle();
    endtask

    task automatic test_block_write();
        logic [2:0] exp_q[$];
        int exp_mw;
`ifdef KF8237_EXTENDED_WRITE_EN
        exp_mw = 9;
`else
        exp_mw = 6;
`endif
        exp_q = '{ST_S0, ST_S1, ST_S2, ST_S3, ST_S4, ST_S2, ST_S3, ST_S4,
                  ST_S1, ST_S2, ST_S3, ST_S4, ST_SI};
        load_stage(16'h00FE, 16'h0002);
        begin_service(2'b01, 2'b10);
        capture(13);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (tr_st[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL block_state[%0d]: got %0d required %0d", i, tr_st[i], exp_q[i]);
            end
        end
        checks++;
        if (tr_hi[8] !== 8'h01) begin errors++; $display("FAIL block_high_page: got %h required 01", tr_hi[8]); end
        checks++;
        if (tr_lo[5] !== 8'hFF) begin errors++; $display("FAIL block_low: got %h required ff", tr_lo[5]); end
        checks++;
        if ($countones(tr_ir) !== 9) begin errors++; $display("FAIL block_ior: got %0d required 9", $countones(tr_ir)); end
        checks++;
        if ($countones(tr_mw) !== exp_mw) begin errors++; $display("FAIL block_memw: got %0d required %0d", $countones(tr_mw), exp_mw); end
        checks++;
        if ((tr_mr | tr_iw) !== 64'h0) begin errors++; $display("FAIL block_other_strobes: got %h required 0", tr_mr | tr_iw); end
        checks++;
        if ($countones(tr_nw) !== 3) begin errors++; $display("FAIL block_next_word: got %0d required 3", $countones(tr_nw)); end
        checks++;
        if (tr_eop !== 64'h1000 || tr_td !== 64'h1000) begin
            errors++;
            $display("FAIL block_eop: got eop=%h td=%h required 1000/1000", tr_eop, tr_td);
        end
        go_idle();
    endtask

    task automatic test_demand();
        logic [2:0] exp_q[$];
        exp_q = '{ST_S0, ST_S1, ST_S2, ST_S3, ST_S4, ST_S2, ST_S3, ST_S4, ST_SI};
        load_stage(16'h2000, 16'h000A);
        begin_service(2'b10, 2'b00);
        capture(6);
        dreq_active = 1'b0;
        capture(3);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (tr_st[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL demand_state[%0d]: got %0d required %0d", i, tr_st[i], exp_q[i]);
            end
        end
        checks++;
        if (tr_td !== 64'h100 || tr_eop !== 64'h0) begin
            errors++;
            $display("FAIL demand_done: got td=%h eop=%h required 100/0", tr_td, tr_eop);
        end
        checks++;
        if ($countones(tr_nw) !== 2) begin errors++; $display("FAIL demand_next_word: got %0d required 2", $countones(tr_nw)); end
        go_idle();
    endtask

    task automatic test_wait_states();
        logic [2:0] exp_q[$];
        exp_q = '{ST_S0, ST_S1, ST_S2, ST_S3, ST_SW, ST_SW, ST_SW, ST_S4, ST_SI};
        load_stage(16'h3000, 16'h000A);
        begin_service(2'b10, 2'b01);
        ready = 1'b0;
        capture(4);
        capture(3);
        ready = 1'b1;
        capture(2);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (tr_st[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL wait_state[%0d]: got %0d required %0d", i, tr_st[i], exp_q[i]);
            end
        end
        checks++;
        if (tr_mr !== 64'hFC) begin errors++; $display("FAIL wait_memr: got %h required fc", tr_mr); end
        checks++;
        if (tr_iw !== 64'hF8) begin errors++; $display("FAIL wait_iow: got %h required f8", tr_iw); end
        checks++;
        if (tr_nw !== 64'h80) begin errors++; $display("FAIL wait_next_word: got %h required 80", tr_nw); end
        go_idle();
    endtask

    task automatic test_cascade();
        logic [2:0] exp_q[$];
        exp_q = '{ST_S0, ST_SC, ST_SC, ST_SC, ST_SI, ST_SI};
        load_stage(16'h0000, 16'h0000);
        begin_service(2'b10, 2'b11);
        capture(4);
        dreq_active = 1'b0;
        capture(2);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (tr_st[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL cascade_state[%0d]: got %0d required %0d", i, tr_st[i], exp_q[i]);
            end
        end
        checks++;
        if (tr_dk !== 64'hE || tr_ae !== 64'h0) begin
            errors++;
            $display("FAIL cascade_dack_aen: got dack=%h aen=%h required e/0", tr_dk, tr_ae);
        end
        checks++;
        if ((tr_mr | tr_mw | tr_ir | tr_iw | tr_nw) !== 64'h0) begin
            errors++;
            $display("FAIL cascade_strobes: got %h required 0", tr_mr | tr_mw | tr_ir | tr_iw | tr_nw);
        end
        checks++;
        if (tr_td !== 64'h10 || tr_hrq !== 64'hF) begin
            errors++;
            $display("FAIL cascade_done: got td=%h hrq=%h required 10/f", tr_td, tr_hrq);
        end
        go_idle();
    endtask

    task automatic test_reset_mid_cycle();
        load_stage(16'h3456, 16'h000A);
        begin_service(2'b10, 2'b10);
        capture(4);
        checks++;
        if (bus_state !== ST_S3) begin errors++; $display("FAIL midreset_pre_state: got %0d required %0d", bus_state, ST_S3); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (all_outs !== 28'h0) begin errors++; $display("FAIL midreset_outputs: got %h required 0", all_outs); end
        checks++;
        if (bus_state !== ST_SI) begin errors++; $display("FAIL midreset_state: got %0d required %0d", bus_state, ST_SI); end
        @(posedge clock);
        reset = 1'b0;
        go_idle();
    endtask

    task automatic test_external_eop();
        logic [2:0] exp_q[$];
        exp_q = '{ST_S0, ST_S1, ST_S2, ST_S3, ST_S4, ST_SI};
        load_stage(16'h4000, 16'h000A);
        begin_service(2'b10, 2'b10);
        capture(3);
        external_end_of_process = 1'b1;
        capture(1);
        external_end_of_process = 1'b0;
        capture(2);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (tr_st[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL eop_state[%0d]: got %0d required %0d", i, tr_st[i], exp_q[i]);
            end
        end
        checks++;
        if (tr_eop !== 64'h20 || tr_td !== 64'h20) begin
            errors++;
            $display("FAIL eop_pulse: got eop=%h td=%h required 20/20", tr_eop, tr_td);
        end
        checks++;
        if (tr_nw !== 64'h10) begin errors++; $display("FAIL eop_next_word: got %h required 10", tr_nw); end
        go_idle();
    endtask

    task automatic test_hlda_abort();
        logic [2:0] exp_q[$];
        int exp_mw;
`ifdef KF8237_EXTENDED_WRITE_EN
        exp_mw = 1;
`else
        exp_mw = 0;
`endif
        exp_q = '{ST_S0, ST_S1, ST_S2, ST_SI, ST_SI};
        load_stage(16'h5000, 16'h000A);
        begin_service(2'b01, 2'b10);
        capture(3);
        hold_acknowledge = 1'b0;
        capture(2);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (tr_st[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL abort_state[%0d]: got %0d required %0d", i, tr_st[i], exp_q[i]);
            end
        end
        checks++;
        if (tr_nw !== 64'h0 || tr_eop !== 64'h0) begin
            errors++;
            $display("FAIL abort_no_advance: got nw=%h eop=%h required 0/0", tr_nw, tr_eop);
        end
        checks++;
        if (tr_td !== 64'h8) begin errors++; $display("FAIL abort_done: got %h required 8", tr_td); end
        checks++;
        if (tr_ir !== 64'h4 || $countones(tr_mw) !== exp_mw) begin
            errors++;
            $display("FAIL abort_strobes: got ior=%h memw_count=%0d required 4/%0d", tr_ir, $countones(tr_mw), exp_mw);
        end
        checks++;
        if (m_addr !== 16'h5000) begin errors++; $display("FAIL abort_address: got %h required 5000", m_addr); end
        go_idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        clear_trace();
        test_reset();
        test_single_read();
        test_block_write();
        test_demand();
        test_wait_states();
        test_cascade();
        test_reset_mid_cycle();
        test_external_eop();
        test_hlda_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
